// File: rtl/sfx_scheduler.sv
// Sound-effect scheduler: arbitrates NUM_SRC requesters onto the single
// speaker tone path. Each granted effect plays for a programmed number of
// sample ticks with optional linear decay, followed by a silent gap.
module sfx_scheduler #(
   parameter int NUM_SRC     = 4,
   parameter int LEN_W       = 16,
   parameter int GAP_TICKS   = 8,
   parameter int DECAY_TICKS = 0,
   parameter int MAX_LEVEL   = 27
) (
   input  logic                     Clk,
   input  logic                     reset_n,
   input  logic                     sample_tick,
   input  logic [NUM_SRC-1:0]       req,
   input  logic [5*NUM_SRC-1:0]     req_level,
   input  logic [LEN_W*NUM_SRC-1:0] req_len,
   output logic [4:0]               Sound,
   output logic                     active,
   output logic [NUM_SRC-1:0]       grant,
   output logic [NUM_SRC-1:0]       done
);

   localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
   localparam int CNT_W = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PLAY = 2'd1,
      GAP  = 2'd2
   } state_t;

   state_t                        state_q, state_d;
   logic [NUM_SRC-1:0]            pending_q, pending_d;
   logic [NUM_SRC-1:0][4:0]       lvl_q, lvl_d;
   logic [NUM_SRC-1:0][LEN_W-1:0] len_q, len_d;
   logic [IDX_W-1:0]              owner_q, owner_d;
   logic [LEN_W-1:0]              remain_q, remain_d;
   logic [CNT_W-1:0]              gap_cnt_q, gap_cnt_d;
   logic [CNT_W-1:0]              decay_cnt_q, decay_cnt_d;
   logic [4:0]                    sound_q, sound_d;
   logic                          active_q, active_d;
   logic [NUM_SRC-1:0]            grant_q, grant_d;
   logic [NUM_SRC-1:0]            done_q, done_d;

   logic                          any_pend_s;
   logic [IDX_W-1:0]              top_idx_s;
   logic                          start_s;

   // Levels above MAX_LEVEL would read as silence downstream, so pin them.
   function automatic logic [4:0] clamp_level(input logic [4:0] lvl);
      if (lvl > 5'(MAX_LEVEL)) begin
         clamp_level = 5'(MAX_LEVEL);
      end else begin
         clamp_level = lvl;
      end
   endfunction

   // Priority encoder: highest-index pending requester wins.
   always_comb begin
      any_pend_s = 1'b0;
      top_idx_s  = {IDX_W{1'b0}};
      for (int i = 0; i < NUM_SRC; i++) begin
         if (pending_q[i]) begin
            any_pend_s = 1'b1;
            top_idx_s  = IDX_W'(i);
         end else begin
            any_pend_s = any_pend_s;
         end
      end
   end

   // Next-state, sequencing and request-capture logic.
   always_comb begin
      state_d     = state_q;
      pending_d   = pending_q;
      lvl_d       = lvl_q;
      len_d       = len_q;
      owner_d     = owner_q;
      remain_d    = remain_q;
      gap_cnt_d   = gap_cnt_q;
      decay_cnt_d = decay_cnt_q;
      sound_d     = sound_q;
      grant_d     = grant_q;
      done_d      = {NUM_SRC{1'b0}};
      start_s     = 1'b0;

      case (state_q)
         IDLE: begin
            if (any_pend_s) begin
               start_s = 1'b1;
            end else begin
               sound_d = 5'd0;
               grant_d = {NUM_SRC{1'b0}};
            end
         end
         PLAY: begin
            // A pending entry at or above the owner covers both preempt and retrigger.
            if (any_pend_s && (top_idx_s >= owner_q)) begin
               start_s = 1'b1;
            end else if (sample_tick) begin
               if (remain_q == LEN_W'(1)) begin
                  done_d[owner_q] = 1'b1;
                  sound_d         = 5'd0;
                  grant_d         = {NUM_SRC{1'b0}};
                  gap_cnt_d       = {CNT_W{1'b0}};
                  if (GAP_TICKS > 0) begin
                     state_d = GAP;
                  end else begin
                     state_d = IDLE;
                  end
               end else begin
                  if (remain_q > LEN_W'(1)) begin
                     remain_d = remain_q - LEN_W'(1);
                  end else begin
                     remain_d = remain_q;
                  end
                  if (DECAY_TICKS > 0) begin
                     if (decay_cnt_q >= CNT_W'(DECAY_TICKS - 1)) begin
                        decay_cnt_d = {CNT_W{1'b0}};
                        if (sound_q != 5'd0) begin
                           sound_d = sound_q - 5'd1;
                        end else begin
                           sound_d = 5'd0;
                        end
                     end else begin
                        decay_cnt_d = decay_cnt_q + CNT_W'(1);
                     end
                  end else begin
                     decay_cnt_d = {CNT_W{1'b0}};
                  end
               end
            end else begin
               remain_d = remain_q;
            end
         end
         GAP: begin
            // Pending requests, whatever their priority, wait for the gap to expire.
            if (sample_tick) begin
               if (gap_cnt_q >= CNT_W'(GAP_TICKS - 1)) begin
                  state_d = IDLE;
               end else begin
                  gap_cnt_d = gap_cnt_q + CNT_W'(1);
               end
            end else begin
               gap_cnt_d = gap_cnt_q;
            end
         end
         default: begin
            state_d = IDLE;
            sound_d = 5'd0;
            grant_d = {NUM_SRC{1'b0}};
         end
      endcase

      if (start_s) begin
         state_d              = PLAY;
         owner_d              = top_idx_s;
         grant_d              = {{(NUM_SRC-1){1'b0}}, 1'b1} << top_idx_s;
         sound_d              = lvl_q[top_idx_s];
         remain_d             = len_q[top_idx_s];
         decay_cnt_d          = {CNT_W{1'b0}};
         pending_d[top_idx_s] = 1'b0;
      end else begin
         owner_d = owner_q;
      end

      // Capture runs after the grant clear so a same-cycle request is kept.
      for (int i = 0; i < NUM_SRC; i++) begin
         if (req[i] && (req_len[i*LEN_W +: LEN_W] != {LEN_W{1'b0}})) begin
            pending_d[i] = 1'b1;
            lvl_d[i]     = clamp_level(req_level[i*5 +: 5]);
            len_d[i]     = req_len[i*LEN_W +: LEN_W];
         end else begin
            pending_d[i] = pending_d[i];
         end
      end

      active_d = (state_d == PLAY);
   end

   // State and output registers; reset silences the speaker immediately.
   always_ff @(posedge Clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         pending_q   <= {NUM_SRC{1'b0}};
         lvl_q       <= {(NUM_SRC*5){1'b0}};
         len_q       <= {(NUM_SRC*LEN_W){1'b0}};
         owner_q     <= {IDX_W{1'b0}};
         remain_q    <= {LEN_W{1'b0}};
         gap_cnt_q   <= {CNT_W{1'b0}};
         decay_cnt_q <= {CNT_W{1'b0}};
         sound_q     <= 5'd0;
         active_q    <= 1'b0;
         grant_q     <= {NUM_SRC{1'b0}};
         done_q      <= {NUM_SRC{1'b0}};
      end else begin
         state_q     <= state_d;
         pending_q   <= pending_d;
         lvl_q       <= lvl_d;
         len_q       <= len_d;
         owner_q     <= owner_d;
         remain_q    <= remain_d;
         gap_cnt_q   <= gap_cnt_d;
         decay_cnt_q <= decay_cnt_d;
         sound_q     <= sound_d;
         active_q    <= active_d;
         grant_q     <= grant_d;
         done_q      <= done_d;
      end
   end

   assign Sound  = sound_q;
   assign active = active_q;
   assign grant  = grant_q;
   assign done   = done_q;

endmodule

// File: tb/tb_sfx_scheduler.sv
// Bench for sfx_scheduler: two instances (no decay / decay every 2 ticks).
// Stimulus pushes the expected output snapshots; a monitor pops one entry
// whenever a DUT's outputs change (or on an explicit probe) and compares
// the snapshot plus the number of sample ticks issued so far.
module tb_sfx_scheduler;

   logic Clk     = 1'b0;
   logic reset_n = 1'b1;
   always #5 Clk = ~Clk;

   logic        tick_a = 1'b0, tick_b = 1'b0;
   logic [3:0]  req_a  = 4'd0, req_b  = 4'd0;
   logic [19:0] lvl_a  = 20'd0, lvl_b = 20'd0;
   logic [63:0] len_a  = 64'd0, len_b = 64'd0;
   logic [4:0]  snd_a, snd_b;
   logic        act_a, act_b;
   logic [3:0]  gnt_a, gnt_b, done_a, done_b;

   sfx_scheduler #(.NUM_SRC(4), .LEN_W(16), .GAP_TICKS(8), .DECAY_TICKS(0), .MAX_LEVEL(27)) dut_a (
      .Clk(Clk), .reset_n(reset_n), .sample_tick(tick_a), .req(req_a),
      .req_level(lvl_a), .req_len(len_a), .Sound(snd_a), .active(act_a),
      .grant(gnt_a), .done(done_a));

   sfx_scheduler #(.NUM_SRC(4), .LEN_W(16), .GAP_TICKS(8), .DECAY_TICKS(2), .MAX_LEVEL(27)) dut_b (
      .Clk(Clk), .reset_n(reset_n), .sample_tick(tick_b), .req(req_b),
      .req_level(lvl_b), .req_len(len_b), .Sound(snd_b), .active(act_b),
      .grant(gnt_b), .done(done_b));

   typedef struct packed {
      logic [4:0]  snd;
      logic [3:0]  gnt;
      logic [3:0]  dn;
      logic        act;
      logic [31:0] ticks;
   } exp_t;

   exp_t  q_a[$];
   exp_t  q_b[$];
   int    n_checks = 0;
   int    n_errors = 0;
   int    ticks_a  = 0;
   int    ticks_b  = 0;
   bit    mon_en   = 1'b0;
   bit    probe    = 1'b0;
   logic [13:0] prev_a, prev_b;

   task automatic mon_check(input bit is_b, input logic [13:0] cur, input int ticks);
      exp_t e;
      exp_t got;
      bit   empty;
      got   = {cur, 32'(ticks)};
      empty = is_b ? (q_b.size() == 0) : (q_a.size() == 0);
      n_checks++;
      if (empty) begin
         n_errors++;
         $display("FAIL dut_%s unexpected_output: got snd=%0d gnt=%b done=%b act=%b tick=%0d, required no change",
                  is_b ? "b" : "a", got.snd, got.gnt, got.dn, got.act, ticks);
      end else begin
         if (is_b) e = q_b.pop_front();
         else      e = q_a.pop_front();
         if (got !== e) begin
            n_errors++;
            $display("FAIL dut_%s output_snapshot: got snd=%0d gnt=%b done=%b act=%b tick=%0d, required snd=%0d gnt=%b done=%b act=%b tick=%0d",
                     is_b ? "b" : "a", got.snd, got.gnt, got.dn, got.act, got.ticks,
                     e.snd, e.gnt, e.dn, e.act, e.ticks);
         end
      end
   endtask

   // Monitor: compare on every output change or probe request.
   always @(negedge Clk) begin
      if (mon_en) begin
         if (({snd_a, gnt_a, done_a, act_a} !== prev_a) || probe)
            mon_check(1'b0, {snd_a, gnt_a, done_a, act_a}, ticks_a);
         if (({snd_b, gnt_b, done_b, act_b} !== prev_b) || probe)
            mon_check(1'b1, {snd_b, gnt_b, done_b, act_b}, ticks_b);
      end
      prev_a <= {snd_a, gnt_a, done_a, act_a};
      prev_b <= {snd_b, gnt_b, done_b, act_b};
   end

   task automatic push_a(input int s, input logic [3:0] g, input logic [3:0] d, input bit a, input int toff);
      exp_t e;
      e = {5'(s), g, d, a, 32'(ticks_a + toff)};
      q_a.push_back(e);
   endtask

   task automatic push_b(input int s, input logic [3:0] g, input logic [3:0] d, input bit a, input int toff);
      exp_t e;
      e = {5'(s), g, d, a, 32'(ticks_b + toff)};
      q_b.push_back(e);
   endtask

   task automatic set_req_a(input int src, input logic [4:0] lv, input logic [15:0] ln);
      req_a[src]          = 1'b1;
      lvl_a[src*5 +: 5]   = lv;
      len_a[src*16 +: 16] = ln;
   endtask

   task automatic set_req_b(input int src, input logic [4:0] lv, input logic [15:0] ln);
      req_b[src]          = 1'b1;
      lvl_b[src*5 +: 5]   = lv;
      len_b[src*16 +: 16] = ln;
   endtask

   task automatic step(input bit ta, input bit tb);
      tick_a = ta;
      tick_b = tb;
      @(posedge Clk);
      if (ta) ticks_a++;
      if (tb) ticks_b++;
      #1;
      tick_a = 1'b0;
      tick_b = 1'b0;
      req_a  = 4'd0;
      req_b  = 4'd0;
   endtask

   task automatic probe_idle();
      push_a(0, 4'b0000, 4'b0000, 1'b0, 0);
      push_b(0, 4'b0000, 4'b0000, 1'b0, 0);
      probe = 1'b1;
      step(1'b0, 1'b0);
      probe = 1'b0;
   endtask

   initial begin
      // 1: reset held across ticks, then released with no requests
      #1 reset_n = 1'b0;
      repeat (3) step(1'b1, 1'b1);
      mon_en = 1'b1;
      probe_idle();
      step(1'b1, 1'b1);
      reset_n = 1'b1;
      repeat (3) step(1'b1, 1'b1);
      probe_idle();

      // 2: single effect, level 10, length 3, then an 8-tick gap
      push_a(10, 4'b0010, 4'b0000, 1'b1, 0);
      push_a(0,  4'b0000, 4'b0010, 1'b0, 3);
      push_a(0,  4'b0000, 4'b0000, 1'b0, 3);
      push_a(7,  4'b0010, 4'b0000, 1'b1, 11);
      push_a(0,  4'b0000, 4'b0010, 1'b0, 12);
      push_a(0,  4'b0000, 4'b0000, 1'b0, 12);
      set_req_a(1, 5'd10, 16'd3);
      step(1'b0, 1'b0);
      step(1'b0, 1'b0);
      repeat (3) step(1'b1, 1'b0);
      step(1'b0, 1'b0);
      set_req_a(1, 5'd7, 16'd1);
      step(1'b0, 1'b0);
      repeat (8) step(1'b1, 1'b0);
      step(1'b0, 1'b0);
      step(1'b1, 1'b0);
      step(1'b0, 1'b0);
      repeat (10) step(1'b1, 1'b0);

      // 3: src0 preempted by src3, src0 never resumed
      push_a(12, 4'b0001, 4'b0000, 1'b1, 0);
      push_a(20, 4'b1000, 4'b0000, 1'b1, 2);
      push_a(0,  4'b0000, 4'b1000, 1'b0, 7);
      push_a(0,  4'b0000, 4'b0000, 1'b0, 7);
      set_req_a(0, 5'd12, 16'd100);
      step(1'b0, 1'b0);
      step(1'b0, 1'b0);
      repeat (2) step(1'b1, 1'b0);
      set_req_a(3, 5'd20, 16'd5);
      step(1'b0, 1'b0);
      step(1'b0, 1'b0);
      repeat (5) step(1'b1, 1'b0);
      step(1'b0, 1'b0);
      repeat (12) step(1'b1, 1'b0);
      repeat (3) step(1'b0, 1'b0);

      // retrigger of the playing source restarts it without a done pulse
      push_a(8,  4'b0010, 4'b0000, 1'b1, 0);
      push_a(11, 4'b0010, 4'b0000, 1'b1, 2);
      push_a(0,  4'b0000, 4'b0010, 1'b0, 4);
      push_a(0,  4'b0000, 4'b0000, 1'b0, 4);
      set_req_a(1, 5'd8, 16'd10);
      step(1'b0, 1'b0);
      step(1'b0, 1'b0);
      repeat (2) step(1'b1, 1'b0);
      set_req_a(1, 5'd11, 16'd2);
      step(1'b0, 1'b0);
      step(1'b0, 1'b0);
      repeat (2) step(1'b1, 1'b0);
      step(1'b0, 1'b0);
      repeat (10) step(1'b1, 1'b0);

      // 4: simultaneous src0 and src2 -> src2, gap, src0
      push_a(9, 4'b0100, 4'b0000, 1'b1, 0);
      push_a(0, 4'b0000, 4'b0100, 1'b0, 2);
      push_a(0, 4'b0000, 4'b0000, 1'b0, 2);
      push_a(6, 4'b0001, 4'b0000, 1'b1, 10);
      push_a(0, 4'b0000, 4'b0001, 1'b0, 12);
      push_a(0, 4'b0000, 4'b0000, 1'b0, 12);
      set_req_a(0, 5'd6, 16'd2);
      set_req_a(2, 5'd9, 16'd2);
      step(1'b0, 1'b0);
      step(1'b0, 1'b0);
      repeat (2) step(1'b1, 1'b0);
      step(1'b0, 1'b0);
      repeat (8) step(1'b1, 1'b0);
      step(1'b0, 1'b0);
      repeat (2) step(1'b1, 1'b0);
      step(1'b0, 1'b0);
      repeat (10) step(1'b1, 1'b0);

      // 5: level 31 clamps to 27; zero length is ignored
      push_a(27, 4'b0100, 4'b0000, 1'b1, 0);
      push_a(0,  4'b0000, 4'b0100, 1'b0, 1);
      push_a(0,  4'b0000, 4'b0000, 1'b0, 1);
      set_req_a(2, 5'd31, 16'd1);
      step(1'b0, 1'b0);
      step(1'b0, 1'b0);
      step(1'b1, 1'b0);
      step(1'b0, 1'b0);
      repeat (10) step(1'b1, 1'b0);
      set_req_a(1, 5'd15, 16'd0);
      repeat (3) step(1'b0, 1'b0);
      probe_idle();

      // 6: decay every 2 ticks on dut_b, level 5, length 20
      push_b(5, 4'b0001, 4'b0000, 1'b1, 0);
      push_b(4, 4'b0001, 4'b0000, 1'b1, 2);
      push_b(3, 4'b0001, 4'b0000, 1'b1, 4);
      push_b(2, 4'b0001, 4'b0000, 1'b1, 6);
      push_b(1, 4'b0001, 4'b0000, 1'b1, 8);
      push_b(0, 4'b0001, 4'b0000, 1'b1, 10);
      push_b(0, 4'b0000, 4'b0001, 1'b0, 20);
      push_b(0, 4'b0000, 4'b0000, 1'b0, 20);
      set_req_b(0, 5'd5, 16'd20);
      step(1'b0, 1'b0);
      step(1'b0, 1'b0);
      repeat (20) step(1'b0, 1'b1);
      step(1'b0, 1'b0);
      repeat (10) step(1'b0, 1'b1);

      // async reset mid-effect with a lower-priority request pending
      push_b(9, 4'b0010, 4'b0000, 1'b1, 0);
      push_b(8, 4'b0010, 4'b0000, 1'b1, 2);
      push_b(0, 4'b0000, 4'b0000, 1'b0, 2);
      set_req_b(1, 5'd9, 16'd20);
      step(1'b0, 1'b0);
      step(1'b0, 1'b0);
      repeat (2) step(1'b0, 1'b1);
      set_req_b(0, 5'd3, 16'd4);
      step(1'b0, 1'b0);
      #2 reset_n = 1'b0;
      @(posedge Clk);
      #1 reset_n = 1'b1;
      repeat (12) step(1'b0, 1'b1);
      probe_idle();

      // every expected snapshot must have been consumed
      repeat (2) step(1'b0, 1'b0);
      mon_en = 1'b0;
      n_checks++;
      if (q_a.size() != 0) begin
         n_errors++;
         $display("FAIL dut_a leftover_expected: got %0d unconsumed entries, required 0", q_a.size());
      end
      n_checks++;
      if (q_b.size() != 0) begin
         n_errors++;
         $display("FAIL dut_b leftover_expected: got %0d unconsumed entries, required 0", q_b.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
